mc_sequencer: RTL and testbench

Multi-cycle control sequencer for the RV32I-subset datapath. It replaces the single-cycle opcode decoder with a Moore/Mealy FSM that steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It sequences the shared instruction/data memory through a req/ready handshake and drives every datapath enable and mux select. It sits between the instruction register (opcode source), the ALU (branch compare result) and the unified memory port.

---
 rtl/mc_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_mc_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle control FSM for the RV32I-subset datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the
// unified memory req/ready handshake and every datapath enable/select.
// Optional build macro MC_SEQ_PERF_EN adds the 32-bit retired counter.
module mc_sequencer #(
  parameter int unsigned MEM_WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic        timeout,
  output logic [2:0]  state
`ifdef MC_SEQ_PERF_EN
  ,
  output logic [31:0] retired
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  // instr[6:2] encodings of the supported instruction classes
  localparam logic [4:0] OP_R  = 5'b01100;
  localparam logic [4:0] OP_I  = 5'b00100;
  localparam logic [4:0] OP_LD = 5'b00000;
  localparam logic [4:0] OP_ST = 5'b01000;
  localparam logic [4:0] OP_BR = 5'b11000;

  // wait counter only needs to reach MEM_WAIT_MAX-1 before the trap fires
  localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam bit TMO_EN = (MEM_WAIT_MAX != 0);
  localparam logic [CW-1:0] WAIT_LAST = CW'((MEM_WAIT_MAX == 0) ? 0 : MEM_WAIT_MAX - 1);

  // datapath control bundle, decoded from state (plus mem_ready/branch_taken)
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
  } ctl_t;

  state_e        st;
  logic [4:0]    op_q;
  logic [CW-1:0] wait_cnt;
  logic          wait_hit;
  ctl_t          ctl;

  // an unanswered request cycle that would bring the counter to MEM_WAIT_MAX
  assign wait_hit = TMO_EN && !mem_ready && (wait_cnt == WAIT_LAST);

  // FSM: state, latched opcode, handshake wait counter, sticky trap flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      op_q     <= '0;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          wait_cnt <= '0;
          st       <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            st       <= S_DECODE;
          end else if (wait_hit) begin
            timeout  <= 1'b1;
            st       <= S_TRAP;
          end else if (TMO_EN) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          wait_cnt <= '0;
          op_q     <= opcode;
          case (opcode)
            OP_R, OP_I, OP_LD, OP_ST, OP_BR: st <= S_EXEC;
            default: begin
              illegal <= 1'b1;
              st      <= S_TRAP;
            end
          endcase
        end
        S_EXEC: begin
          wait_cnt <= '0;
          case (op_q)
            OP_R, OP_I:   st <= S_WB;
            OP_LD, OP_ST: st <= S_MEM;
            OP_BR:        st <= S_FETCH;
            default: begin
              illegal <= 1'b1;
              st      <= S_TRAP;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            st       <= (op_q == OP_LD) ? S_WB : S_FETCH;
          end else if (wait_hit) begin
            timeout  <= 1'b1;
            st       <= S_TRAP;
          end else if (TMO_EN) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB: begin
          wait_cnt <= '0;
          st       <= S_FETCH;
        end
        S_TRAP: begin
          // only rst_n leaves TRAP
          wait_cnt <= '0;
          st       <= S_TRAP;
        end
        default: begin
          wait_cnt <= '0;
          st       <= S_TRAP;
        end
      endcase
    end
  end

  // control decode: Moore on state, Mealy only for FETCH ir/pc writes and branch pc_write
  always_comb begin
    ctl = '0;
    case (st)
      S_FETCH: begin
        ctl.mem_req  = 1'b1;
        ctl.ir_write = mem_ready;
        ctl.pc_write = mem_ready;
      end
      S_EXEC: begin
        case (op_q)
          OP_R: ctl.alu_op = 2'b10;
          OP_I: begin
            ctl.alu_op    = 2'b11;
            ctl.alu_src_b = 1'b1;
          end
          OP_LD, OP_ST: begin
            ctl.alu_op    = 2'b00;
            ctl.alu_src_b = 1'b1;
          end
          OP_BR: begin
            ctl.alu_op   = 2'b01;
            ctl.pc_write = branch_taken;
            ctl.pc_src   = 1'b1;
          end
          default: ctl = '0;
        endcase
      end
      S_MEM: begin
        ctl.mem_req   = 1'b1;
        ctl.iord      = 1'b1;
        ctl.mem_we    = (op_q == OP_ST);
        ctl.alu_src_b = 1'b1;
      end
      S_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = (op_q == OP_LD);
      end
      default: ctl = '0;
    endcase
  end

  assign mem_req    = ctl.mem_req;
  assign mem_we     = ctl.mem_we;
  assign iord       = ctl.iord;
  assign ir_write   = ctl.ir_write;
  assign pc_write   = ctl.pc_write;
  assign pc_src     = ctl.pc_src;
  assign alu_src_b  = ctl.alu_src_b;
  assign alu_op     = ctl.alu_op;
  assign reg_write  = ctl.reg_write;
  assign mem_to_reg = ctl.mem_to_reg;
  assign state      = st;

`ifdef MC_SEQ_PERF_EN
  logic retire;

  // an instruction retires on its normal transition back into FETCH
  assign retire = (st == S_WB) ||
                  (st == S_MEM  && mem_ready && op_q == OP_ST) ||
                  (st == S_EXEC && op_q == OP_BR);

  // free-running retired count, wraps naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired <= '0;
    else if (retire) retired <= retired + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: directed self-checking bench for mc_sequencer
// (built with MEM_WAIT_MAX=4; retired checks only when MC_SEQ_PERF_EN is defined).
module tb_mc_sequencer;

  localparam logic [4:0] OP_R  = 5'b01100;
  localparam logic [4:0] OP_I  = 5'b00100;
  localparam logic [4:0] OP_LD = 5'b00000;
  localparam logic [4:0] OP_ST = 5'b01000;
  localparam logic [4:0] OP_BR = 5'b11000;

  // ctl = {mem_req,mem_we,iord,ir_write,pc_write,pc_src,alu_src_b,alu_op[1:0],reg_write,mem_to_reg}
  localparam logic [10:0] C_NONE  = 11'b000_0000_0000;
  localparam logic [10:0] C_F_RDY = 11'b100_1100_0000;
  localparam logic [10:0] C_F_WT  = 11'b100_0000_0000;
  localparam logic [10:0] C_EX_R  = 11'b000_0000_1000;
  localparam logic [10:0] C_EX_I  = 11'b000_0001_1100;
  localparam logic [10:0] C_EX_M  = 11'b000_0001_0000;
  localparam logic [10:0] C_EX_BT = 11'b000_0110_0100;
  localparam logic [10:0] C_EX_BN = 11'b000_0010_0100;
  localparam logic [10:0] C_M_LD  = 11'b101_0001_0000;
  localparam logic [10:0] C_M_ST  = 11'b111_0001_0000;
  localparam logic [10:0] C_WB_R  = 11'b000_0000_0010;
  localparam logic [10:0] C_WB_LD = 11'b000_0000_0011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  opcode;
  logic        branch_taken, mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_write, mem_to_reg, illegal, timeout;
  logic [2:0]  state;
`ifdef MC_SEQ_PERF_EN
  logic [31:0] retired;
`endif
  logic [10:0] ctl;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t0;
  logic seen;

  always #5 clk = ~clk;

  mc_sequencer #(.MEM_WAIT_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .timeout(timeout),
    .state(state)
`ifdef MC_SEQ_PERF_EN
    , .retired(retired)
`endif
  );

  assign ctl = {mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                alu_src_b, alu_op, reg_write, mem_to_reg};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs are then changed well clear of the edge
  task automatic tick;
    @(posedge clk);
    #2;
    cyc++;
  endtask

  // one zero-wait R-type starting in FETCH
  task automatic run_r;
    opcode    = OP_R;
    mem_ready = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    rst_n = 1'b0; opcode = 5'd0; branch_taken = 1'b0; mem_ready = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ctl", 32'(ctl), 32'(C_NONE));
    chk("rst_flags", {30'd0, illegal, timeout}, 32'd0);
`ifdef MC_SEQ_PERF_EN
    chk("rst_retired", retired, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_to_fetch", 32'(state), 32'd1);

    // R-type, zero wait: 1,2,3,5,1; opcode scrambled after DECODE is ignored
    t0 = cyc; opcode = OP_R; mem_ready = 1'b1; #1;
    chk("r_fetch_ctl", 32'(ctl), 32'(C_F_RDY));
    tick(); chk("r_decode_st", 32'(state), 32'd2); chk("r_decode_ctl", 32'(ctl), 32'(C_NONE));
    tick(); opcode = 5'b11111; #1;
    chk("r_exec_st", 32'(state), 32'd3); chk("r_exec_ctl", 32'(ctl), 32'(C_EX_R));
    tick(); chk("r_wb_st", 32'(state), 32'd5); chk("r_wb_ctl", 32'(ctl), 32'(C_WB_R));
    tick(); chk("r_back_fetch", 32'(state), 32'd1);
    chk("r_latency", cyc - t0, 32'd4);

    // load with one wait cycle in FETCH and one in MEM: 5 + 2 = 7 cycles
    t0 = cyc; opcode = OP_LD; mem_ready = 1'b0; #1;
    chk("ld_fetch_wait_ctl", 32'(ctl), 32'(C_F_WT));
    tick(); mem_ready = 1'b1; #1;
    chk("ld_fetch_rdy_st", 32'(state), 32'd1); chk("ld_fetch_rdy_ctl", 32'(ctl), 32'(C_F_RDY));
    tick(); tick(); mem_ready = 1'b0; #1;
    chk("ld_exec_ctl", 32'(ctl), 32'(C_EX_M));
    tick(); chk("ld_mem_wait_ctl", 32'(ctl), 32'(C_M_LD));
    tick(); mem_ready = 1'b1; #1;
    chk("ld_mem_held_st", 32'(state), 32'd4); chk("ld_mem_held_ctl", 32'(ctl), 32'(C_M_LD));
    tick(); chk("ld_wb_ctl", 32'(ctl), 32'(C_WB_LD));
    tick(); chk("ld_latency", cyc - t0, 32'd7); chk("ld_back_fetch", 32'(state), 32'd1);

    // store: mem_we only in MEM, no reg_write, straight back to FETCH
    t0 = cyc; opcode = OP_ST;
    tick(); tick(); chk("st_exec_ctl", 32'(ctl), 32'(C_EX_M));
    tick(); chk("st_mem_ctl", 32'(ctl), 32'(C_M_ST));
    tick(); chk("st_back_fetch", 32'(state), 32'd1); chk("st_latency", cyc - t0, 32'd4);

    // I-ALU
    opcode = OP_I;
    tick(); tick(); chk("i_exec_ctl", 32'(ctl), 32'(C_EX_I));
    tick(); chk("i_wb_ctl", 32'(ctl), 32'(C_WB_R));
    tick();

    // branch taken / not taken, 3 cycles each
    t0 = cyc; opcode = OP_BR; branch_taken = 1'b1;
    tick(); tick(); chk("br_t_exec_ctl", 32'(ctl), 32'(C_EX_BT));
    tick(); chk("br_t_back_fetch", 32'(state), 32'd1); chk("br_latency", cyc - t0, 32'd3);
    branch_taken = 1'b0;
    tick(); tick(); chk("br_n_exec_ctl", 32'(ctl), 32'(C_EX_BN));
    tick(); chk("br_n_back_fetch", 32'(state), 32'd1);
`ifdef MC_SEQ_PERF_EN
    chk("retired_6", retired, 32'd6);
`endif

    // timeout: 4 unanswered FETCH cycles trap, 3 do not
    mem_ready = 1'b0;
    repeat (3) tick();
    chk("tmo_not_yet", 32'(state), 32'd1);
    tick();
    chk("tmo_trap_st", 32'(state), 32'd6);
    chk("tmo_flags", {30'd0, illegal, timeout}, 32'd1);
    chk("tmo_ctl", 32'(ctl), 32'(C_NONE));
`ifdef MC_SEQ_PERF_EN
    chk("tmo_retired", retired, 32'd6);
`endif

    // reset clears timeout; then illegal opcode traps after DECODE
    rst_n = 1'b0; #1;
    chk("tmo_rst_flags", {30'd0, illegal, timeout}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick(); opcode = 5'b11111; mem_ready = 1'b1;
    tick(); chk("ill_decode_st", 32'(state), 32'd2);
    tick(); chk("ill_trap_st", 32'(state), 32'd6);
    chk("ill_flags", {30'd0, illegal, timeout}, 32'd2);
    seen = 1'b0;
    repeat (20) begin tick(); seen = seen | mem_req; end
    chk("ill_memreq_20", {31'd0, seen}, 32'd0);
    chk("ill_still_trap", 32'(state), 32'd6);
    #1 rst_n = 1'b0; #1;
    chk("ill_rst_clear", {29'd0, state, illegal}, 32'd0);

    // asynchronous reset drops an outstanding request immediately
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0;
    tick(); #1;
    chk("async_req_on", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0; #1;
    chk("async_req_off", {31'd0, mem_req}, 32'd0);

    // three R-types from reset
    @(negedge clk); rst_n = 1'b1;
    tick();
    repeat (3) run_r();
    chk("r3_state", 32'(state), 32'd1);
`ifdef MC_SEQ_PERF_EN
    chk("r3_retired", retired, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
